register_file_32bit: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the RISC datapath (divider/ALU core).
- Provides two independent combinational read ports (A and B) and one synchronous write port.
- Sits between instruction decode (source and destination addresses) and the execute/write-back stages.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 28 ++
 rtl/register_file_32bit.sv | 51 +++++
 tb/tb_register_file_32bit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing constants and word/address types for the 32 x 32 register file.
package regfile_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int DEPTH      = 32;

   typedef logic [DATA_WIDTH-1:0] regWord_t;
   typedef logic [ADDR_WIDTH-1:0] regAddr_t;

   localparam regAddr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux plus hardwired-zero check.
// With REGFILE_WRITE_BYPASS_EN defined, a same-cycle write to the read address is forwarded.
module regfile_read_port
   import regfile_pkg::*;
(
   input  regWord_t [DEPTH-1:0] regs,
   input  regAddr_t             addr,
`ifdef REGFILE_WRITE_BYPASS_EN
   input  logic                 rst,
   input  logic                 write,
   input  regAddr_t             destAddr,
   input  regWord_t             destData,
`endif
   output regWord_t             data
);

   always_comb begin
      data = regs[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (write && !rst && (destAddr == addr))
         data = destData;
`endif
      // Register 0 reads zero regardless of storage or forwarding.
      if (addr == ZERO_REG)
         data = '0;
   end

endmodule

// File: rtl/register_file_32bit.sv
// 32-entry x 32-bit register file: two combinational read ports, one synchronous write port.
// Optional write-through forwarding on the read ports when REGFILE_WRITE_BYPASS_EN is defined.
module register_file_32bit
   import regfile_pkg::*;
(
   input  logic     clk,
   input  logic     Reset,
   input  logic     Write,
   input  regAddr_t AddrA,
   input  regAddr_t AddrB,
   input  regAddr_t DestAddr,
   input  regWord_t DestData,
   output regWord_t DataA,
   output regWord_t DataB
);

   regWord_t [DEPTH-1:0] regs;

   // Reset clears everything asynchronously; register 0 is never written so it stays zero.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset)
         regs <= '0;
      else if (Write && (DestAddr != ZERO_REG))
         regs[DestAddr] <= DestData;
   end

   regfile_read_port portA (
      .regs     (regs),
      .addr     (AddrA),
`ifdef REGFILE_WRITE_BYPASS_EN
      .rst      (Reset),
      .write    (Write),
      .destAddr (DestAddr),
      .destData (DestData),
`endif
      .data     (DataA)
   );

   regfile_read_port portB (
      .regs     (regs),
      .addr     (AddrB),
`ifdef REGFILE_WRITE_BYPASS_EN
      .rst      (Reset),
      .write    (Write),
      .destAddr (DestAddr),
      .destData (DestData),
`endif
      .data     (DataB)
   );

endmodule

// File: tb/tb_register_file_32bit.sv
// Self-checking bench for register_file_32bit: directed cases plus random traffic against an array model.
module tb_register_file_32bit;

   logic        clk = 1'b0;
   logic        Reset;
   logic        Write;
   logic [4:0]  AddrA, AddrB, DestAddr;
   logic [31:0] DestData;
   logic [31:0] DataA, DataB;

   int numCompared   = 0;
   int numMismatched = 0;

   logic [31:0] model [32];

   register_file_32bit dut (
      .clk      (clk),
      .Reset    (Reset),
      .Write    (Write),
      .AddrA    (AddrA),
      .AddrB    (AddrB),
      .DestAddr (DestAddr),
      .DestData (DestData),
      .DataA    (DataA),
      .DataB    (DataB)
   );

   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("FAIL %s: got %h, want %h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] expRead(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (Write && !Reset && (a == DestAddr)) return DestData;
`endif
      return model[a];
   endfunction

   task automatic checkPorts(input string tag);
      checkEq({tag, "_A"}, DataA, expRead(AddrA));
      checkEq({tag, "_B"}, DataB, expRead(AddrB));
   endtask

   task automatic clearModel();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // Waits for the rising edge and applies whatever write is currently presented.
   task automatic clockEdge();
      @(posedge clk);
      if (Write && !Reset && (DestAddr != 5'd0)) model[DestAddr] = DestData;
      #1;
   endtask

   task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      Write    = 1'b1;
      DestAddr = a;
      DestData = d;
      clockEdge();
      Write = 1'b0;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      #2 Reset = 1'b1;
      clearModel();
      #1 Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Write = 1'b0;
      AddrA = '0; AddrB = '0; DestAddr = '0; DestData = '0;
      clearModel();
      @(negedge clk);
      @(negedge clk);
      Reset = 1'b0;
      AddrA = 5'd5; AddrB = 5'd31;
      #1;
      checkEq("rstState_A", DataA, 32'h0);
      checkEq("rstState_B", DataB, 32'h0);

      // Asynchronous reset mid-cycle
      writeReg(5'd5, 32'hDEADBEEF);
      AddrA = 5'd5;
      #1 checkEq("preRst", DataA, 32'hDEADBEEF);
      @(negedge clk);
      #2 Reset = 1'b1;
      clearModel();
      #1 checkEq("asyncRst", DataA, 32'h0);

      // Write while reset is high must be dropped
      Write = 1'b1; DestAddr = 5'd9; DestData = 32'hCAFEF00D; AddrA = 5'd9;
      clockEdge();
      checkEq("wrInRst", DataA, 32'h0);
      @(negedge clk);
      Write = 1'b0; Reset = 1'b0;
      #1 checkEq("wrInRstAfter", DataA, 32'h0);

      // Fill sweep
      for (int i = 0; i < 32; i++) writeReg(i[4:0], i);
      for (int i = 0; i < 32; i++) begin
         AddrA = i[4:0]; AddrB = i[4:0];
         #1;
         checkEq($sformatf("fillA%0d", i), DataA, (i == 0) ? 32'h0 : i);
         checkEq($sformatf("fillB%0d", i), DataB, (i == 0) ? 32'h0 : i);
      end

      // Write enable
      pulseReset();
      @(negedge clk);
      Write = 1'b0; DestAddr = 5'd7; DestData = 32'h12345678; AddrA = 5'd7;
      clockEdge();
      checkEq("wrDisabled", DataA, 32'h0);
      writeReg(5'd7, 32'h12345678);
      checkEq("wrEnabled", DataA, 32'h12345678);

      // Zero register
      writeReg(5'd0, 32'hFFFFFFFF);
      AddrA = 5'd0; AddrB = 5'd0;
      #1;
      checkEq("zeroA", DataA, 32'h0);
      checkEq("zeroB", DataB, 32'h0);

      // Read during write
      writeReg(5'd3, 32'hA5A5A5A5);
      @(negedge clk);
      AddrA = 5'd3; Write = 1'b1; DestAddr = 5'd3; DestData = 32'h5A5A5A5A;
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      checkEq("rdwBefore", DataA, 32'h5A5A5A5A);
`else
      checkEq("rdwBefore", DataA, 32'hA5A5A5A5);
`endif
      clockEdge();
      Write = 1'b0;
      checkEq("rdwAfter", DataA, 32'h5A5A5A5A);

      // Dual port with address swap
      writeReg(5'd10, 32'h0000AAAA);
      writeReg(5'd20, 32'h00005555);
      AddrA = 5'd10; AddrB = 5'd20;
      #1;
      checkEq("dualA", DataA, 32'h0000AAAA);
      checkEq("dualB", DataB, 32'h00005555);
      AddrA = 5'd20; AddrB = 5'd10;
      #1;
      checkEq("swapA", DataA, 32'h00005555);
      checkEq("swapB", DataB, 32'h0000AAAA);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 59) == 0) begin
            #1 Reset = 1'b1;
            clearModel();
            #1 checkPorts("rndRst");
            Reset = 1'b0;
         end
         Write    = ($urandom_range(0, 3) != 0);
         DestAddr = 5'($urandom_range(0, 31));
         DestData = $urandom;
         AddrA    = ($urandom_range(0, 3) == 0) ? DestAddr : 5'($urandom_range(0, 31));
         AddrB    = 5'($urandom_range(0, 31));
         #1 checkPorts("rndPre");
         clockEdge();
         checkPorts("rndPost");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
